// File: rtl/kanagawa_hal_mc_ready_valid_fifo_pkg.sv
// Shared types and the round-robin pick used by the multi-channel FIFO.
// Channel ids are carried at MAX_CH width; the top narrows them for its ports.
package kanagawa_hal_mc_ready_valid_fifo_pkg;

  localparam int unsigned MAX_CH = 32;

  typedef logic [$clog2(MAX_CH)-1:0] chan_id_t;

  // First set bit of mask at or after start, wrapping over n channels.
  // Returns start when mask is empty.
  function automatic chan_id_t rr_next(
    input logic [MAX_CH-1:0] mask,
    input chan_id_t          start,
    input int unsigned       n
  );
    chan_id_t    pick;
    logic        found;
    int unsigned idx;
    pick  = start;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      idx = (32'(start) + i) % n;
      if (i < n && !found && mask[idx[4:0]]) begin
        pick  = chan_id_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/kanagawa_hal_fifo_chan_ctrl.sv
// Per-channel pointer/count bookkeeping for one region of the shared store.
// Ports: push side (in_valid/flush -> in_ready/push), grant -> pop, status usedw/almost_full/empty, pointers.
module kanagawa_hal_fifo_chan_ctrl #(
  parameter int unsigned LOG_DEPTH          = 5,
  parameter int unsigned DEPTH              = 32,
  parameter int unsigned ALMOSTFULL_ENTRIES = 8,
  localparam int unsigned UW                = LOG_DEPTH + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rst_sync,
  input  logic                 in_valid,
  input  logic                 flush,
  input  logic                 grant,
  output logic                 in_ready,
  output logic                 push,
  output logic [UW-1:0]        usedw,
  output logic                 almost_full,
  output logic                 empty,
  output logic [LOG_DEPTH-1:0] wr_ptr,
  output logic [LOG_DEPTH-1:0] rd_ptr
);

  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [UW-1:0]        count_q, count_d;
  logic                 pop;

  assign in_ready    = !rst_sync && (count_q < UW'(DEPTH)) && !flush;
  assign push        = in_valid && in_ready;
  assign pop         = grant && !flush;
  assign usedw       = count_q;
  assign almost_full = count_q >= UW'(DEPTH - ALMOSTFULL_ENTRIES);
  assign empty       = (count_q == '0);
  assign wr_ptr      = wr_ptr_q;
  assign rd_ptr      = rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + UW'(1);
        2'b01:   count_d = count_q - UW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/kanagawa_hal_mc_ready_valid_fifo.sv
// N-channel ready/valid FIFO on one shared store, round-robin merged to one tagged output.
// Ports: in_valid/in_ready/in_data/flush/in_usedw/in_almost_full per channel; out_valid/out_ready/out_data/out_channel.
module kanagawa_hal_mc_ready_valid_fifo
  import kanagawa_hal_mc_ready_valid_fifo_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS       = 4,
  parameter int unsigned LOG_DEPTH          = 5,
  parameter int unsigned DEPTH              = 32,
  parameter int unsigned WIDTH              = 16,
  parameter int unsigned ALMOSTFULL_ENTRIES = 8,
  localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int unsigned UW = LOG_DEPTH + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CHANNELS-1:0]    in_valid,
  output logic [NUM_CHANNELS-1:0]    in_ready,
  input  logic [NUM_CHANNELS*WIDTH-1:0] in_data,
  output logic [NUM_CHANNELS*UW-1:0] in_usedw,
  output logic [NUM_CHANNELS-1:0]    in_almost_full,
  input  logic [NUM_CHANNELS-1:0]    flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [CW-1:0]              out_channel
);

  logic                 rst_sync_q, rst_sync_d;
  logic [NUM_CHANNELS-1:0] empty, push, grant;
  logic [LOG_DEPTH-1:0] wr_ptr [NUM_CHANNELS];
  logic [LOG_DEPTH-1:0] rd_ptr [NUM_CHANNELS];
  logic [UW-1:0]        usedw  [NUM_CHANNELS];
  logic [WIDTH-1:0]     mem_q  [NUM_CHANNELS][DEPTH];

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [CW-1:0]        out_channel_q, out_channel_d;
  chan_id_t             rr_ptr_q, rr_ptr_d;

  logic [MAX_CH-1:0]    req;
  chan_id_t             sel;
  logic                 load;
  logic [WIDTH-1:0]     rd_data;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    kanagawa_hal_fifo_chan_ctrl #(
      .LOG_DEPTH          (LOG_DEPTH),
      .DEPTH              (DEPTH),
      .ALMOSTFULL_ENTRIES (ALMOSTFULL_ENTRIES)
    ) u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .rst_sync    (rst_sync_q),
      .in_valid    (in_valid[c]),
      .flush       (flush[c]),
      .grant       (grant[c]),
      .in_ready    (in_ready[c]),
      .push        (push[c]),
      .usedw       (usedw[c]),
      .almost_full (in_almost_full[c]),
      .empty       (empty[c]),
      .wr_ptr      (wr_ptr[c]),
      .rd_ptr      (rd_ptr[c])
    );
    assign in_usedw[c*UW +: UW] = usedw[c];

    a_no_flush_grant: assert property (
      @(posedge clk) disable iff (!rst_n) !(grant[c] && flush[c]));
    a_count_max: assert property (
      @(posedge clk) disable iff (!rst_n) usedw[c] <= UW'(DEPTH));
  end

  // Holds in_ready low for the first edge after reset release.
  always_comb rst_sync_d = 1'b0;

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (push[c]) mem_q[c][wr_ptr[c]] <= in_data[c*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    req = '0;
    req[NUM_CHANNELS-1:0] = ~empty & ~flush;
    load    = !out_valid_q || out_ready;
    sel     = rr_next(req, rr_ptr_q, NUM_CHANNELS);
    rd_data = '0;
    grant   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (sel == chan_id_t'(c)) begin
        rd_data  = mem_q[c][rd_ptr[c]];
        grant[c] = load && (|req);
      end
    end
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    rr_ptr_d      = rr_ptr_q;
    if (load) begin
      out_valid_d = |req;
      if (|req) begin
        out_data_d    = rd_data;
        out_channel_d = CW'(sel);
        rr_ptr_d = (sel == chan_id_t'(NUM_CHANNELS - 1)) ?
                   '0 : sel + chan_id_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      rr_ptr_q      <= '0;
    end else begin
      rst_sync_q    <= rst_sync_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;

endmodule
